// File: rtl/dm_cache_if.sv
// CPU load/store port and line-wide memory port of dm_cache, plus its hit/miss counters.
interface dm_cache_if #(
   parameter int unsigned LINE_W = 128
);
   logic              cpu_r;
   logic              cpu_w;
   logic [31:0]       cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [31:0]       cpu_rdata;
   logic              cpu_stall;
   logic              mem_r;
   logic              mem_w;
   logic [31:0]       mem_addr;
   logic [LINE_W-1:0] mem_w_data;
   logic [LINE_W-1:0] mem_r_data;
   logic              mem_ready;
   logic [31:0]       hit_cnt;
   logic [31:0]       miss_cnt;

   modport slave (
      input  cpu_r, cpu_w, cpu_addr, cpu_wdata, mem_r_data, mem_ready,
      output cpu_rdata, cpu_stall, mem_r, mem_w, mem_addr, mem_w_data, hit_cnt, miss_cnt
   );

   modport master (
      output cpu_r, cpu_w, cpu_addr, cpu_wdata, mem_r_data, mem_ready,
      input  cpu_rdata, cpu_stall, mem_r, mem_w, mem_addr, mem_w_data, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate data cache; stalls the CPU on a miss,
// writes back a dirty victim, refills the line, then retries the access as a hit.
module dm_cache #(
   parameter int unsigned INDEX_WIDTH       = 3,
   parameter int unsigned LINE_OFFSET_WIDTH = 2,
   parameter int unsigned SPACE_OFFSET      = 2
) (
   input logic       clk,
   input logic       rstn,
   dm_cache_if.slave bus
);
   localparam int unsigned LINES  = 1 << INDEX_WIDTH;
   localparam int unsigned WORDS  = 1 << LINE_OFFSET_WIDTH;
   localparam int unsigned LINE_W = 32 * WORDS;
   localparam int unsigned LOW_W  = LINE_OFFSET_WIDTH + SPACE_OFFSET;
   localparam int unsigned TAG_W  = 32 - INDEX_WIDTH - LOW_W;

   typedef enum logic [1:0] {IDLE, WRITEBACK, GAP, REFILL} state_t;

   state_t                         r_state;
   logic [LINES-1:0]               r_valid;
   logic [LINES-1:0]               r_dirty;
   logic [TAG_W-1:0]               r_tag  [LINES];
   logic [LINE_W-1:0]              r_data [LINES];
   logic [TAG_W+INDEX_WIDTH-1:0]   r_line;
   logic                           r_mem_r;
   logic                           r_mem_w;
   logic [31:0]                    r_mem_addr;
   logic [LINE_W-1:0]              r_mem_w_data;
   logic [31:0]                    r_hit_cnt;
   logic [31:0]                    r_miss_cnt;

   logic [LINE_OFFSET_WIDTH-1:0]   w_offset;
   logic [INDEX_WIDTH-1:0]         w_index;
   logic [TAG_W-1:0]               w_tag;
   logic [INDEX_WIDTH-1:0]         w_fill_idx;
   logic [TAG_W-1:0]               w_fill_tag;
   logic                           w_req;
   logic                           w_hit;
   logic                           w_stall;
   logic                           w_wr_hit;
   logic [31:0]                    w_word;
   logic                           w_unused;

   assign w_offset   = bus.cpu_addr[SPACE_OFFSET +: LINE_OFFSET_WIDTH];
   assign w_index    = bus.cpu_addr[LOW_W +: INDEX_WIDTH];
   assign w_tag      = bus.cpu_addr[31 -: TAG_W];
   assign w_fill_idx = r_line[INDEX_WIDTH-1:0];
   assign w_fill_tag = r_line[INDEX_WIDTH +: TAG_W];
   assign w_unused   = ^bus.cpu_addr[SPACE_OFFSET-1:0];

   assign w_req    = bus.cpu_r | bus.cpu_w;
   assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
   assign w_stall  = (r_state != IDLE) || (w_req && !w_hit);
   assign w_wr_hit = (r_state == IDLE) && bus.cpu_w && w_hit;
   assign w_word   = r_data[w_index][32*w_offset +: 32];

   // Gated by rstn so the CPU side goes quiet the moment reset is asserted.
   assign bus.cpu_stall  = rstn && w_stall;
   assign bus.cpu_rdata  = (rstn && bus.cpu_r && !w_stall) ? w_word : '0;
   assign bus.mem_r      = r_mem_r;
   assign bus.mem_w      = r_mem_w;
   assign bus.mem_addr   = r_mem_addr;
   assign bus.mem_w_data = r_mem_w_data;
   assign bus.hit_cnt    = r_hit_cnt;
   assign bus.miss_cnt   = r_miss_cnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= IDLE;
         r_valid      <= '0;
         r_dirty      <= '0;
         r_line       <= '0;
         r_mem_r      <= 1'b0;
         r_mem_w      <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_w_data <= '0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req && w_hit) begin
                  r_hit_cnt <= r_hit_cnt + 32'd1;
                  if (bus.cpu_w) r_dirty[w_index] <= 1'b1;
               end else if (w_req) begin
                  r_miss_cnt <= r_miss_cnt + 32'd1;
                  r_line     <= {w_tag, w_index};
                  if (r_valid[w_index] && r_dirty[w_index]) begin
                     r_state      <= WRITEBACK;
                     r_mem_w      <= 1'b1;
                     r_mem_addr   <= {r_tag[w_index], w_index, {LOW_W{1'b0}}};
                     r_mem_w_data <= r_data[w_index];
                  end else begin
                     r_state    <= REFILL;
                     r_mem_r    <= 1'b1;
                     r_mem_addr <= {w_tag, w_index, {LOW_W{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               if (bus.mem_ready) begin
                  r_state      <= GAP;
                  r_mem_w      <= 1'b0;
                  r_mem_addr   <= '0;
                  r_mem_w_data <= '0;
               end
            end
            GAP: begin
               r_state    <= REFILL;
               r_mem_r    <= 1'b1;
               r_mem_addr <= {r_line, {LOW_W{1'b0}}};
            end
            REFILL: begin
               if (bus.mem_ready) begin
                  r_state             <= IDLE;
                  r_mem_r             <= 1'b0;
                  r_mem_addr          <= '0;
                  r_valid[w_fill_idx] <= 1'b1;
                  r_dirty[w_fill_idx] <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Tag/data arrays carry no reset; valid bits alone decide residency.
   always_ff @(posedge clk) begin
      if (r_state == REFILL && bus.mem_ready) begin
         r_data[w_fill_idx] <= bus.mem_r_data;
         r_tag[w_fill_idx]  <= w_fill_tag;
      end else if (w_wr_hit) begin
         r_data[w_index][32*w_offset +: 32] <= bus.cpu_wdata;
      end
   end
endmodule
